rx_slot_ctrl: RTL and testbench

Receive-slot ring controller for the ethpipe RX path. It replaces the single host/ethernet ownership bit with a ring of SLOTS frame buffers and does the following:
- hands the ethernet writer the index of the next free slot;
- latches each completed frame's timestamp and length;
- exposes the oldest full slot to the host through a small 16-bit register window;
- generates a coalesced interrupt.

It sits in the PCIe clock domain between the synchronised `rx_done`/`rx_empty` handshake of the ethpipe port and the Wishbone register decoder.

---
 rtl/rx_slot_ctrl_if.sv | 27 ++
 rtl/rx_slot_ctrl.sv | 157 +++++++++++++++
 tb/tb_rx_slot_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_slot_ctrl_if.sv
// Bundles the ethernet-writer handshake and the host register window of rx_slot_ctrl.
// master = ethernet writer plus register decoder; slave = the slot controller.
interface rx_slot_ctrl_if #(
  parameter int unsigned PTR_W = 2
);
  logic             eth_done;
  logic [31:0]      eth_timestamp;
  logic [11:0]      eth_frame_len;
  logic [PTR_W-1:0] eth_slot;
  logic             eth_empty;
  logic             reg_rd;
  logic             reg_wr;
  logic [2:0]       reg_addr;
  logic [15:0]      reg_wdata;
  logic [15:0]      reg_rdata;
  logic             reg_ack;

  modport master (
    output eth_done, eth_timestamp, eth_frame_len, reg_rd, reg_wr, reg_addr, reg_wdata,
    input  eth_slot, eth_empty, reg_rdata, reg_ack
  );

  modport slave (
    input  eth_done, eth_timestamp, eth_frame_len, reg_rd, reg_wr, reg_addr, reg_wdata,
    output eth_slot, eth_empty, reg_rdata, reg_ack
  );
endinterface

// File: rtl/rx_slot_ctrl.sv
// RX slot ring controller: hands out free slots to the ethernet writer, keeps per-slot
// timestamp/length, exposes the oldest full slot to the host and raises a coalesced interrupt.
module rx_slot_ctrl #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  rx_slot_ctrl_if.slave bus,
  output logic          irq
);

  localparam int unsigned CntW = PTR_W + 1;

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrTsLo    = 3'd1;
  localparam logic [2:0] AddrTsHi    = 3'd2;
  localparam logic [2:0] AddrLen     = 3'd3;
  localparam logic [2:0] AddrRelease = 3'd4;
  localparam logic [2:0] AddrDrop    = 3'd5;
  localparam logic [2:0] AddrThresh  = 3'd6;
  localparam logic [2:0] AddrTimeout = 3'd7;

  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [31:0]      ts_q  [SLOTS];
  logic [11:0]      len_q [SLOTS];
  logic             irq_en_q, irq_en_d;
  logic [3:0]       irq_thresh_q, irq_thresh_d;
  logic [15:0]      irq_timeout_q, irq_timeout_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [15:0]      timer_q, timer_d;
  logic             irq_pend_q, irq_pend_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             ack_q;

  logic       full;
  logic       accept;
  logic       rel;
  logic       drop;
  logic       wr_status, wr_drop, wr_thresh, wr_timeout;
  logic [3:0] thresh_eff;
  logic       thresh_hit;
  logic       timeout_hit;

  assign full   = (count_q == CntW'(SLOTS));
  assign accept = bus.eth_done & ~full;
  assign drop   = bus.eth_done & full;
  assign rel    = bus.reg_wr & (bus.reg_addr == AddrRelease) & (count_q != '0);

  assign wr_status  = bus.reg_wr & (bus.reg_addr == AddrStatus);
  assign wr_drop    = bus.reg_wr & (bus.reg_addr == AddrDrop);
  assign wr_thresh  = bus.reg_wr & (bus.reg_addr == AddrThresh);
  assign wr_timeout = bus.reg_wr & (bus.reg_addr == AddrTimeout);

  assign thresh_eff  = (irq_thresh_q == 4'd0) ? 4'd1 : irq_thresh_q;
  assign thresh_hit  = (8'(count_q) >= 8'(thresh_eff));
  assign timeout_hit = (irq_timeout_q != 16'd0) && (timer_q == irq_timeout_q - 16'd1);

  always_comb begin
    wp_d    = accept ? wp_q + PTR_W'(1) : wp_q;
    rp_d    = rel ? rp_q + PTR_W'(1) : rp_q;
    count_d = count_q;
    unique case ({accept, rel})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    irq_en_d      = wr_status  ? bus.reg_wdata[14]  : irq_en_q;
    irq_thresh_d  = wr_thresh  ? bus.reg_wdata[3:0] : irq_thresh_q;
    irq_timeout_d = wr_timeout ? bus.reg_wdata      : irq_timeout_q;

    // A host clear wins over a simultaneous drop.
    drop_cnt_d = drop_cnt_q;
    if (wr_drop) begin
      drop_cnt_d = 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    timer_d = timer_q;
    if (rel || (count_q == '0) || irq_pend_q) begin
      timer_d = 16'd0;
    end else if (timer_q != 16'hFFFF) begin
      timer_d = timer_q + 16'd1;
    end

    irq_pend_d = irq_pend_q;
    if (!irq_en_q || (count_d == '0)) begin
      irq_pend_d = 1'b0;
    end else if (thresh_hit || timeout_hit) begin
      irq_pend_d = 1'b1;
    end
  end

  always_comb begin
    rdata_d = 16'd0;
    if (bus.reg_rd) begin
      unique case (bus.reg_addr)
        AddrStatus:  rdata_d = {irq_pend_q, irq_en_q, 2'b00, 4'(count_q),
                                1'b0, 3'(rp_q), 1'b0, 3'(wp_q)};
        AddrTsLo:    rdata_d = ts_q[rp_q][15:0];
        AddrTsHi:    rdata_d = ts_q[rp_q][31:16];
        AddrLen:     rdata_d = {4'b0000, len_q[rp_q]};
        AddrRelease: rdata_d = 16'd0;
        AddrDrop:    rdata_d = drop_cnt_q;
        AddrThresh:  rdata_d = {12'd0, irq_thresh_q};
        AddrTimeout: rdata_d = irq_timeout_q;
        default:     rdata_d = 16'd0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      irq_en_q      <= 1'b0;
      irq_thresh_q  <= 4'd1;
      irq_timeout_q <= 16'd0;
      drop_cnt_q    <= 16'd0;
      timer_q       <= 16'd0;
      irq_pend_q    <= 1'b0;
      rdata_q       <= 16'd0;
      ack_q         <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      irq_en_q      <= irq_en_d;
      irq_thresh_q  <= irq_thresh_d;
      irq_timeout_q <= irq_timeout_d;
      drop_cnt_q    <= drop_cnt_d;
      timer_q       <= timer_d;
      irq_pend_q    <= irq_pend_d;
      rdata_q       <= rdata_d;
      ack_q         <= bus.reg_rd | bus.reg_wr;
    end
  end

  // Slot metadata needs no reset; stale contents are readable by design.
  always_ff @(posedge sys_clk) begin
    if (accept && !sys_rst) begin
      ts_q[wp_q]  <= bus.eth_timestamp;
      len_q[wp_q] <= bus.eth_frame_len;
    end
  end

  assign bus.eth_slot  = wp_q;
  assign bus.eth_empty = ~full;
  assign bus.reg_rdata = rdata_q;
  assign bus.reg_ack   = ack_q;
  assign irq           = irq_pend_q;

endmodule

// File: tb/tb_rx_slot_ctrl.sv
// Directed self-checking bench for rx_slot_ctrl (SLOTS = 4).
module tb_rx_slot_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic irq;

  int n_checks = 0;
  int n_fail   = 0;

  rx_slot_ctrl_if #(.PTR_W(2)) bus ();

  rx_slot_ctrl #(.SLOTS(4), .PTR_W(2)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
    .irq     (irq)
  );

  always #4 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [15:0] d, output logic ack);
    bus.reg_rd   = 1'b1;
    bus.reg_addr = a;
    tick();
    d            = bus.reg_rdata;
    ack          = bus.reg_ack;
    bus.reg_rd   = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
    bus.reg_wr    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    tick();
    bus.reg_wr    = 1'b0;
  endtask

  task automatic frame(input logic [31:0] ts, input logic [11:0] len);
    bus.eth_done      = 1'b1;
    bus.eth_timestamp = ts;
    bus.eth_frame_len = len;
    tick();
    bus.eth_done      = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic        a;
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    n_checks++;
    if (bus.eth_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_eth_empty got %b want 1", bus.eth_empty);
    end
    n_checks++;
    if (bus.eth_slot !== 2'd0) begin
      n_fail++; $display("FAIL reset_eth_slot got %0d want 0", bus.eth_slot);
    end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_checks++;
    if (bus.reg_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack got %b want 0", bus.reg_ack);
    end
    reg_read(3'd0, d, a);
    n_checks++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL reset_status_ack got %b want 1", a); end
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_status got %h want 0000", d); end
    tick();
    n_checks++;
    if (bus.reg_ack !== 1'b0) begin
      n_fail++; $display("FAIL ack_one_cycle got %b want 0", bus.reg_ack);
    end
    reg_read(3'd6, d, a);
    n_checks++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL reset_thresh got %h want 0001", d); end
  endtask

  task automatic test_fill_drop();
    logic [15:0] d;
    logic        a;
    for (int i = 0; i < 4; i++) frame(32'd100 + 32'(i), 12'd64 + 12'(i));
    n_checks++;
    if (bus.eth_empty !== 1'b0) begin
      n_fail++; $display("FAIL full_eth_empty got %b want 0", bus.eth_empty);
    end
    n_checks++;
    if (bus.eth_slot !== 2'd0) begin
      n_fail++; $display("FAIL full_eth_slot got %0d want 0", bus.eth_slot);
    end
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0400) begin n_fail++; $display("FAIL full_status got %h want 0400", d); end
    frame(32'd999, 12'd999);
    reg_read(3'd5, d, a);
    n_checks++;
    if (d !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got %0d want 1", d); end
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0400) begin n_fail++; $display("FAIL drop_status got %h want 0400", d); end
    reg_write(3'd5, 16'h1234);
    reg_read(3'd5, d, a);
    n_checks++;
    if (d !== 16'd0) begin n_fail++; $display("FAIL drop_clear got %0d want 0", d); end
  endtask

  task automatic test_drain();
    logic [15:0] d;
    logic        a;
    for (int i = 0; i < 4; i++) begin
      reg_read(3'd1, d, a);
      n_checks++;
      if (d !== 16'd100 + 16'(i)) begin
        n_fail++; $display("FAIL drain_ts[%0d] got %0d want %0d", i, d, 100 + i);
      end
      reg_read(3'd3, d, a);
      n_checks++;
      if (d !== 16'd64 + 16'(i)) begin
        n_fail++; $display("FAIL drain_len[%0d] got %0d want %0d", i, d, 64 + i);
      end
      reg_write(3'd4, 16'hFFFF);
    end
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL drain_status got %h want 0000", d); end
    reg_write(3'd4, 16'h0000);
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++; $display("FAIL empty_release got %h want 0000", d);
    end
    reg_read(3'd4, d, a);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL release_read got %h want 0000", d); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] d;
    logic        a;
    for (int i = 0; i < 4; i++) frame(32'd10 + 32'(i), 12'd20 + 12'(i));
    bus.eth_done      = 1'b1;
    bus.eth_timestamp = 32'hDEAD_BEEF;
    bus.eth_frame_len = 12'd555;
    bus.reg_wr        = 1'b1;
    bus.reg_addr      = 3'd4;
    tick();
    bus.eth_done = 1'b0;
    bus.reg_wr   = 1'b0;
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0310) begin n_fail++; $display("FAIL same_cycle_status got %h want 0310", d); end
    reg_read(3'd5, d, a);
    n_checks++;
    if (d !== 16'd1) begin n_fail++; $display("FAIL same_cycle_drop got %0d want 1", d); end
    reg_read(3'd1, d, a);
    n_checks++;
    if (d !== 16'd11) begin n_fail++; $display("FAIL same_cycle_head got %0d want 11", d); end
    for (int i = 0; i < 3; i++) reg_write(3'd4, 16'h0);
    reg_write(3'd5, 16'h0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic        a;
    frame(32'd7, 12'd7);
    bus.eth_done      = 1'b1;
    bus.eth_timestamp = 32'h1234_5678;
    bus.eth_frame_len = 12'hABC;
    bus.reg_wr        = 1'b1;
    bus.reg_addr      = 3'd4;
    tick();
    bus.eth_done = 1'b0;
    bus.reg_wr   = 1'b0;
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0112) begin n_fail++; $display("FAIL b2b_status got %h want 0112", d); end
    reg_read(3'd1, d, a);
    n_checks++;
    if (d !== 16'h5678) begin n_fail++; $display("FAIL b2b_ts_lo got %h want 5678", d); end
    reg_read(3'd2, d, a);
    n_checks++;
    if (d !== 16'h1234) begin n_fail++; $display("FAIL b2b_ts_hi got %h want 1234", d); end
    reg_read(3'd3, d, a);
    n_checks++;
    if (d !== 16'h0ABC) begin n_fail++; $display("FAIL b2b_len got %h want 0abc", d); end
    reg_write(3'd4, 16'h0);
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0022) begin n_fail++; $display("FAIL b2b_final got %h want 0022", d); end
  endtask

  task automatic test_irq_thresh();
    logic [15:0] d;
    logic        a;
    reg_write(3'd0, 16'h4000);
    reg_write(3'd6, 16'd3);
    reg_write(3'd7, 16'd0);
    reg_read(3'd6, d, a);
    n_checks++;
    if (d !== 16'd3) begin n_fail++; $display("FAIL thresh_readback got %0d want 3", d); end
    frame(32'd1, 12'd1);
    frame(32'd2, 12'd2);
    repeat (3) tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_below_thresh got %b want 0", irq); end
    frame(32'd3, 12'd3);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_n1 got %b want 0", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_n2 got %b want 1", irq); end
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'hC321) begin n_fail++; $display("FAIL irq_status got %h want c321", d); end
    reg_write(3'd4, 16'h0);
    reg_write(3'd4, 16'h0);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b want 1", irq); end
    reg_write(3'd4, 16'h0);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask

  task automatic test_irq_timeout();
    reg_write(3'd6, 16'd8);
    reg_write(3'd7, 16'd50);
    frame(32'd5, 12'd5);
    repeat (49) tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b want 0", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL timeout_fire got %b want 1", irq); end
    reg_write(3'd4, 16'h0);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b want 0", irq); end
    frame(32'd6, 12'd6);
    frame(32'd7, 12'd7);
    repeat (27) tick();
    reg_write(3'd4, 16'h0);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL restart_no_irq got %b want 0", irq); end
    repeat (49) tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL restart_early got %b want 0", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL restart_fire got %b want 1", irq); end
    reg_write(3'd0, 16'h0000);
    tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_en_off got %b want 0", irq); end
    reg_write(3'd4, 16'h0);
  endtask

  task automatic test_thresh_zero();
    logic [15:0] d;
    logic        a;
    reg_write(3'd0, 16'h4000);
    reg_write(3'd6, 16'd0);
    reg_write(3'd7, 16'd0);
    frame(32'd9, 12'd9);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL thr0_n1 got %b want 0", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL thr0_n2 got %b want 1", irq); end
    reg_read(3'd6, d, a);
    n_checks++;
    if (d !== 16'd0) begin n_fail++; $display("FAIL thr0_readback got %0d want 0", d); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] d;
    logic        a;
    frame(32'd8, 12'd8);
    sys_rst      = 1'b1;
    bus.reg_rd   = 1'b1;
    bus.reg_addr = 3'd0;
    tick();
    sys_rst    = 1'b0;
    bus.reg_rd = 1'b0;
    n_checks++;
    if (bus.reg_ack !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ack got %b want 0", bus.reg_ack);
    end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq got %b want 0", irq); end
    n_checks++;
    if (bus.eth_slot !== 2'd0) begin
      n_fail++; $display("FAIL midrst_slot got %0d want 0", bus.eth_slot);
    end
    reg_read(3'd0, d, a);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_status got %h want 0000", d); end
    reg_read(3'd6, d, a);
    n_checks++;
    if (d !== 16'd1) begin n_fail++; $display("FAIL midrst_thresh got %0d want 1", d); end
  endtask

  initial begin
    sys_rst           = 1'b1;
    bus.eth_done      = 1'b0;
    bus.eth_timestamp = 32'd0;
    bus.eth_frame_len = 12'd0;
    bus.reg_rd        = 1'b0;
    bus.reg_wr        = 1'b0;
    bus.reg_addr      = 3'd0;
    bus.reg_wdata     = 16'd0;
    test_reset();
    test_fill_drop();
    test_drain();
    test_same_cycle();
    test_back_to_back();
    test_irq_thresh();
    test_irq_timeout();
    test_thresh_zero();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
